// File: rtl/instr_mem_sync_if.sv
// instr_mem_sync_if: fetch, boot-control and load-port bundle between the core fetch stage and instr_mem_sync.
// Latency: none; this is wiring only.
// Backpressure: im_ready gates fetches and loads. The master drives requests and the slave (memory) drives the responses.
interface instr_mem_sync_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int ADDR_W = $clog2(DEPTH);

    // fetch request / response
    logic                    im_cs;
    logic                    im_req;
    logic [ADDR_W+OFF_W-1:0] im_addr;
    logic                    im_reinit;
    logic                    im_ready;
    logic                    im_valid;
    logic [DATA_W-1:0]       im_out;
    logic                    im_misalign;

    // run-time program load port
    logic                    ld_we;
    logic [ADDR_W-1:0]       ld_addr;
    logic [DATA_W-1:0]       ld_data;
    logic                    ld_ack;

    modport master (
        output im_cs, im_req, im_addr, im_reinit,
        output ld_we, ld_addr, ld_data,
        input  im_ready, im_valid, im_out, im_misalign, ld_ack
    );

    modport slave (
        input  im_cs, im_req, im_addr, im_reinit,
        input  ld_we, ld_addr, ld_data,
        output im_ready, im_valid, im_out, im_misalign, ld_ack
    );
endinterface

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: boot-loaded instruction RAM for the fetch stage. The load port is compiled in only with `IM_LOAD_EN.
// Latency: an accepted fetch returns im_valid/im_out/im_misalign 1 cycle later. A load write is acked 1 cycle later.
// Backpressure: none on accepted requests. Fetches and loads are dropped (not stalled) while im_ready is low during boot.
module instr_mem_sync #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int BOOT_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_sync_if.slave   bus
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // registered fetch response, launched one cycle after acceptance
    typedef struct packed {
        logic              vld;
        logic              misalign;
        logic [DATA_W-1:0] dat;
    } fetch_rsp_t;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic              init_last;
    logic [DATA_W-1:0] mem [DEPTH];
    fetch_rsp_t        rsp;

    logic              fetch_acc;
    logic              fetch_misalign;
    logic [ADDR_W-1:0] fetch_idx;
    logic              ld_wr;

    // Built-in boot program. Words past BOOT_WORDS (or past the table) load as zero.
    // The 32-bit table entries are zero-extended or truncated to DATA_W.
    function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] idx);
        logic [31:0]       w;
        logic [DATA_W-1:0] r;
        int                i;
        i = int'(idx);
        w = 32'h0;
        if (i < BOOT_WORDS) begin
            case (i)
                0:       w = 32'h002000B3;
                1:       w = 32'h000100B3;
                2:       w = 32'h00308133;
                3:       w = 32'h001101B3;
                default: w = 32'h0;
            endcase
        end
        r = '0;
        for (int b = 0; b < DATA_W && b < 32; b++) begin
            r[b] = w[b];
        end
        return r;
    endfunction

    assign init_last = (init_cnt == ADDR_W'(DEPTH - 1));
    assign fetch_idx = bus.im_addr[ADDR_W+OFF_W-1:OFF_W];
    assign fetch_acc = bus.im_req & bus.im_cs & (state == ST_READY);

    // Byte-wide words have no offset bits and therefore can never be misaligned.
    generate
        if (OFF_W == 0) begin : g_no_off
            assign fetch_misalign = 1'b0;
        end else begin : g_off
            assign fetch_misalign = |bus.im_addr[OFF_W-1:0];
        end
    endgenerate

    // Boot sequencer: INIT walks every word once, then READY until re-init is requested.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            // im_reinit is deliberately not looked at here; the current boot pass finishes
            init_cnt <= init_last ? '0 : init_cnt + ADDR_W'(1);
            if (init_last) begin
                state <= ST_READY;
            end
        end else if (bus.im_reinit) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end
    end

    // Memory array: the boot sequencer owns the write port in INIT, and the load port owns it in READY.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= boot_word(init_cnt);
            end
`ifdef IM_LOAD_EN
            else if (ld_wr) begin
                mem[bus.ld_addr] <= bus.ld_data;
            end
`endif
        end
    end

    // Fetch response: the read sees pre-edge contents, so a same-cycle load returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp <= '0;
        end else begin
            rsp.vld      <= fetch_acc;
            rsp.misalign <= fetch_acc & fetch_misalign;
            rsp.dat      <= (fetch_acc && !fetch_misalign) ? mem[fetch_idx] : '0;
        end
    end

`ifdef IM_LOAD_EN
    logic ld_ack_q;

    assign ld_wr = bus.ld_we & (state == ST_READY);

    // One-cycle acknowledge for each load write that was accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_ack_q <= 1'b0;
        end else begin
            ld_ack_q <= ld_wr;
        end
    end

    assign bus.ld_ack = ld_ack_q;
`else
    // Load port is not compiled in, so its inputs are only sunk here.
    logic ld_unused;

    assign ld_wr      = 1'b0;
    assign ld_unused  = ld_wr ^ bus.ld_we ^ (^bus.ld_addr) ^ (^bus.ld_data);
    assign bus.ld_ack = 1'b0;
`endif

    assign bus.im_ready    = (state == ST_READY);
    assign bus.im_valid    = rsp.vld;
    assign bus.im_misalign = rsp.misalign;
    assign bus.im_out      = rsp.dat;

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: randomized plus directed stimulus for instr_mem_sync, checked against a cycle-level behavioural model.
// Latency: the model predicts the outputs after each rising edge. They are compared on the following falling edge.
// Backpressure: not applicable; the bench drives every input directly.
module tb_instr_mem_sync;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
`ifdef IM_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    instr_mem_sync_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    instr_mem_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BOOT_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    int          m_left;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_out;
    logic        m_ack;

    logic [31:0] boot_tab [4] = '{32'h002000B3, 32'h000100B3, 32'h00308133, 32'h001101B3};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic load_boot_image();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = (i < 4) ? boot_tab[i] : 32'h0;
        end
    endtask

    // Predict the next outputs from the inputs that the coming edge will sample
    task automatic model_step();
        logic        nv;
        logic        nm;
        logic [31:0] no;
        logic        na;
        nv = 1'b0; nm = 1'b0; no = 32'h0; na = 1'b0;
        if (!rst_n) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
            load_boot_image();
        end else if (m_ready) begin
            if (bus.im_req && bus.im_cs) begin
                nv = 1'b1;
                if (bus.im_addr[1:0] != 2'b00) nm = 1'b1;
                else no = m_mem[bus.im_addr[5:2]];
            end
            if (LOAD_EN && bus.ld_we) begin
                m_mem[bus.ld_addr] = bus.ld_data;
                na = 1'b1;
            end
            if (bus.im_reinit) begin
                m_ready = 1'b0;
                m_left  = DEPTH;
                load_boot_image();
            end
        end else begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end
        m_valid = nv; m_mis = nm; m_out = no; m_ack = na;
    endtask

    // One clock: model, rising edge, then compare everything on the falling edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("im_ready",    32'(bus.im_ready),    32'(m_ready));
        check("im_valid",    32'(bus.im_valid),    32'(m_valid));
        check("im_misalign", 32'(bus.im_misalign), 32'(m_mis));
        check("im_out",      bus.im_out,           m_out);
        check("ld_ack",      32'(bus.ld_ack),      32'(m_ack));
    endtask

    // Count the cycles until im_ready rises. This is bounded so a stuck DUT still reaches the summary.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.im_ready && n < 40) begin
            cycle();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    logic [31:0] exp_seq [5] = '{32'h002000B3, 32'h000100B3, 32'h00308133, 32'h001101B3, 32'h0};

    initial begin
        rst_n         = 1'b0;
        bus.im_cs     = 1'b0;
        bus.im_req    = 1'b0;
        bus.im_addr   = '0;
        bus.im_reinit = 1'b0;
        bus.ld_we     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        m_ready = 1'b0; m_left = DEPTH;
        load_boot_image();

        // reset, then the boot length with no requests
        cycle();
        cycle();
        rst_n = 1'b1;
        wait_ready("boot_len");

        // back-to-back fetches across the boot table and one zero-padded word
        bus.im_cs  = 1'b1;
        bus.im_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.im_addr = 6'(i * 4);
            cycle();
            check("seq_out", bus.im_out, exp_seq[i]);
            check("seq_vld", 32'(bus.im_valid), 32'd1);
        end

        // misaligned fetch
        bus.im_addr = 6'h06;
        cycle();
        check("mis_flag", 32'(bus.im_misalign), 32'd1);
        check("mis_out",  bus.im_out, 32'h0);

        // fetch with chip select low
        bus.im_cs   = 1'b0;
        bus.im_addr = 6'h00;
        cycle();
        check("cs_low_vld", 32'(bus.im_valid), 32'd0);
        check("cs_low_out", bus.im_out, 32'h0);

        // same-cycle load and fetch of word 2
        bus.im_cs   = 1'b1;
        bus.im_addr = 6'h08;
        bus.ld_we   = 1'b1;
        bus.ld_addr = 4'd2;
        bus.ld_data = 32'hDEADBEEF;
        cycle();
        check("wr_old_data", bus.im_out, 32'h00308133);
        check("wr_ack", 32'(bus.ld_ack), 32'(LOAD_EN));
        bus.ld_we = 1'b0;
        cycle();
        check("wr_new_data", bus.im_out, LOAD_EN ? 32'hDEADBEEF : 32'h00308133);

        // re-init restores the boot image; loads in the window are not acked
        bus.im_req    = 1'b0;
        bus.im_reinit = 1'b1;
        cycle();
        bus.im_reinit = 1'b0;
        bus.ld_we     = 1'b1;
        wait_ready("reinit_len");
        bus.ld_we  = 1'b0;
        bus.im_req = 1'b1;
        cycle();
        check("reinit_word2", bus.im_out, 32'h00308133);

        // a reset pulse at init count 7 restarts the full boot
        bus.im_req = 1'b0;
        bus.im_reinit = 1'b1;
        cycle();
        bus.im_reinit = 1'b0;
        repeat (7) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        wait_ready("rst_mid_init_len");

        // random traffic: fetches, loads, occasional re-init and reset
        for (int k = 0; k < 600; k++) begin
            bus.im_cs     = ($urandom_range(0, 7) != 0);
            bus.im_req    = ($urandom_range(0, 3) != 0);
            bus.im_addr   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : {4'($urandom), 2'b00};
            bus.ld_we     = ($urandom_range(0, 3) == 0);
            bus.ld_addr   = 4'($urandom);
            bus.ld_data   = $urandom;
            bus.im_reinit = ($urandom_range(0, 63) == 0);
            rst_n         = ($urandom_range(0, 127) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Parametrised, clocked instruction memory for the RISC core fetch stage. After reset, a boot sequencer loads the built-in default program into a DEPTH-word RAM. The block then serves byte-addressed fetches with a registered request/valid handshake and flags misaligned fetches. A load port lets the program be rewritten at run time.

Parameters:
DATA_W, 32, instruction word width in bits; must be 8 x a power of two; OFF_W = log2(DATA_W/8)
DEPTH, 16, number of words; must be a power of two; ADDR_W = log2(DEPTH)
BOOT_WORDS, 4, number of words taken from the built-in boot table (1..DEPTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
im_cs  in  1  chip select; fetches are ignored while low
im_req  in  1  fetch request
im_addr  in  ADDR_W+OFF_W  byte address (PC); word index = im_addr[ADDR_W+OFF_W-1:OFF_W]
im_reinit  in  1  single-cycle pulse; reruns the boot sequence
im_ready  out  1  high in READY state only
im_valid  out  1  fetch result valid (one-cycle pulse per accepted fetch)
im_out  out  DATA_W  fetched instruction
im_misalign  out  1  accompanies im_valid; set when im_addr[OFF_W-1:0] != 0
ld_we  in  1  load-port write enable (see Optional Feature)
ld_addr  in  ADDR_W  load-port word index
ld_data  in  DATA_W  load-port data
ld_ack  out  1  write completed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at an edge): state=INIT, init counter=0, im_ready=0, im_valid=0, im_out=0, im_misalign=0, ld_ack=0.
- Reset mid-fetch or mid-INIT abandons the operation; the boot sequence always restarts at word 0.
- Boot table, in word order: 32'h002000B3, 32'h000100B3, 32'h00308133, 32'h001101B3. Values are zero-extended or truncated to DATA_W.
- Words at index >= BOOT_WORDS are loaded as 0. BOOT_WORDS greater than 4 pads with 0.
- INIT state: writes one word per cycle, mem[cnt] = boot value, for cnt = 0..DEPTH-1.
  - After writing DEPTH-1, state goes to READY. im_ready rises on the next edge, DEPTH cycles after the reset release edge.
  - During INIT, fetches and ld_we are ignored: no im_valid, no ld_ack.
- READY state, fetch accept: a fetch is accepted when im_req & im_cs & im_ready.
  - Latency is 1 cycle. The next cycle has im_valid=1 and im_out=mem[word index], read before any same-edge write.
  - Misaligned fetch: im_valid=1, im_misalign=1, im_out=0, with no memory access.
  - In any cycle without an accepted fetch, the next cycle has im_valid=0, im_out=0, im_misalign=0.
  - Back-to-back fetches are accepted every cycle.
- Address range: the word index is wholly covered by ADDR_W bits, so there is no out-of-range case. Upper bits beyond ADDR_W+OFF_W do not exist.
- im_reinit in READY: state returns to INIT with cnt=0 and im_ready drops on the next edge. A fetch accepted in the same cycle still completes.
  - im_reinit during INIT is ignored.
- Load port (when compiled in): a write is accepted when ld_we & im_ready and takes effect at that edge. ld_ack=1 for the following cycle.
  - Simultaneous fetch and write to the same word: the fetch returns the old data.
  - Simultaneous write and im_reinit: the write is performed, then overwritten by init.

Optional Feature:
Macro IM_LOAD_EN.
- Defined: the load port is functional as described above.
- Undefined: ld_we, ld_addr and ld_data are ignored, ld_ack is tied 0, and the memory changes only via the boot sequence.

Test Plan:
- Reset release, im_req=0: im_ready=0 for 16 cycles, then 1. im_valid stays 0 throughout.
- READY; fetch im_addr=0x0, 0x4, 0x8, 0xC, 0x10 on back-to-back cycles: im_out = 002000B3, 000100B3, 00308133, 001101B3, 00000000, each with im_valid=1 one cycle after its request.
- Fetch im_addr=0x6: next cycle im_valid=1, im_misalign=1, im_out=0. Fetch with im_cs=0: im_valid stays 0 and im_out=0.
- With IM_LOAD_EN: ld_we=1, ld_addr=2, ld_data=DEADBEEF together with a fetch of 0x8 → fetch returns 00308133 and ld_ack=1. The next fetch of 0x8 returns DEADBEEF.
- With IM_LOAD_EN: after the DEADBEEF write, pulse im_reinit → im_ready low for 16 cycles and ld_we in that window gives no ack. Fetch 0x8 then returns 00308133.
- Assert rst_n=0 for one cycle at init count 7 → full 16-cycle INIT rerun. Without IM_LOAD_EN, ld_we=1 never yields ld_ack and memory is unchanged.
